// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the oversampled UART receive path.
package uart_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ENTRY_W   = DATA_W + 2;
    localparam int unsigned OS_RATE   = 16;
    localparam int unsigned SAMPLE_LO = 7;
    localparam int unsigned SAMPLE_MID = 8;
    localparam int unsigned SAMPLE_HI = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    typedef struct packed {
        logic              parity_err;
        logic              frame_err;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    // Expected parity bit: even parity is the XOR of the data, odd inverts it.
    function automatic logic parity_calc(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CNT_W-1:0] count_q;
    logic             push_c;
    logic             pop_c;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_q];

    assign pop_c  = pop_i && !empty_o;
    assign push_c = push_i && (!full_o || pop_c);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_c) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (pop_c) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// 16x-oversampled 8-bit UART receiver with majority-vote sampling, optional parity,
// framing/overrun detection and a receive FIFO behind a valid/ready interface.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq   = 1000000,
    parameter int unsigned baud_rate  = 9600,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] m_data,
    output logic              m_frame_err,
    output logic              m_parity_err,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W   = $clog2(OS_RATE);
    localparam int unsigned IDX_W   = $clog2(DATA_W);
    localparam int unsigned FCNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] ACC_INC = 32'(baud_rate * OS_RATE);
    localparam logic [31:0] ACC_MOD = 32'(clk_freq);
    localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(SAMPLE_LO);
    localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(SAMPLE_MID);
    localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(SAMPLE_HI);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OS_RATE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    logic [1:0]        sync_q;
    logic              rx_s;
    logic [31:0]       acc_q, acc_d, acc_sum_c;
    logic              tick_q, tick_d;

    rx_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nx_c;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              s_lo_q, s_lo_d;
    logic              s_mid_q, s_mid_d;
    logic              bit_q, bit_d;
    logic              perr_q, perr_d;
    logic              arm_q, arm_d;
    logic              vote_c;
    logic              push_c;
    rx_entry_t         entry_c;

    logic              busy_q;
    logic              overrun_q;
    logic              pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic [ENTRY_W-1:0] fifo_dout;
    rx_entry_t         head_c;

    assign rx_s = sync_q[1];

    // Fractional baud accumulator: averages exactly OS_RATE ticks per bit.
    always_comb begin
        acc_sum_c = acc_q + ACC_INC;
        acc_d     = acc_sum_c;
        tick_d    = 1'b0;
        if (acc_sum_c >= ACC_MOD) begin
            acc_d  = acc_sum_c - ACC_MOD;
            tick_d = 1'b1;
        end
    end

    // Receive FSM next-state; bits are voted at SAMPLE_HI using the two earlier samples.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        s_lo_d   = s_lo_q;
        s_mid_d  = s_mid_q;
        bit_d    = bit_q;
        perr_d   = perr_q;
        arm_d    = arm_q;
        push_c   = 1'b0;
        entry_c  = '0;
        cnt_nx_c = cnt_q + CNT_W'(1);
        vote_c   = (s_lo_q & s_mid_q) | (s_lo_q & rx_s) | (s_mid_q & rx_s);

        if (tick_q && rx_s) begin
            arm_d = 1'b1;
        end

        if (tick_q) begin
            if (state_q != IDLE) begin
                cnt_d = cnt_nx_c;
                if (cnt_nx_c == TICK_LO) begin
                    s_lo_d = rx_s;
                end
                if (cnt_nx_c == TICK_MID) begin
                    s_mid_d = rx_s;
                end
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s && arm_q) begin
                        state_d = START;
                        cnt_d   = '0;
                        idx_d   = '0;
                        perr_d  = 1'b0;
                    end
                end
                START: begin
                    if (cnt_nx_c == TICK_HI) begin
                        bit_d = vote_c;
                    end
                    if (cnt_nx_c == TICK_LAST) begin
                        state_d = bit_q ? IDLE : DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    if (cnt_nx_c == TICK_HI) begin
                        shift_d = {vote_c, shift_q[DATA_W-1:1]};
                    end
                    if (cnt_nx_c == TICK_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (cnt_nx_c == TICK_HI) begin
                        perr_d = (vote_c != parity_calc(shift_q, PARITY_ODD != 0));
                    end
                    if (cnt_nx_c == TICK_LAST) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    // Deciding mid stop bit leaves time to catch a back-to-back start edge.
                    if (cnt_nx_c == TICK_HI) begin
                        push_c             = 1'b1;
                        entry_c.parity_err = perr_q;
                        entry_c.frame_err  = !vote_c;
                        entry_c.data       = shift_q;
                        state_d            = IDLE;
                        if (!vote_c) begin
                            arm_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q    <= 2'b11;
            acc_q     <= '0;
            tick_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            s_lo_q    <= 1'b1;
            s_mid_q   <= 1'b1;
            bit_q     <= 1'b1;
            perr_q    <= 1'b0;
            arm_q     <= 1'b1;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx};
            acc_q     <= acc_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            s_lo_q    <= s_lo_d;
            s_mid_q   <= s_mid_d;
            bit_q     <= bit_d;
            perr_q    <= perr_d;
            arm_q     <= arm_d;
            busy_q    <= (state_d != IDLE);
            overrun_q <= push_c && fifo_full && !pop_c;
        end
    end

    assign pop_c = !fifo_empty && m_ready;

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .data_i  (entry_c),
        .pop_i   (pop_c),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_c       = fifo_dout;
    assign m_data       = head_c.data;
    assign m_frame_err  = head_c.frame_err;
    assign m_parity_err = head_c.parity_err;
    assign m_valid      = (fifo_count != '0);
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 instance (a) and an even-parity instance (b).
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_a, rx_b;
    logic       m_ready_a, m_ready_b;
    logic [7:0] m_data_a, m_data_b;
    logic       m_frame_err_a, m_frame_err_b;
    logic       m_parity_err_a, m_parity_err_b;
    logic       m_valid_a, m_valid_b;
    logic       overrun_a, overrun_b;
    logic       busy_a, busy_b;

    int n_cmp  = 0;
    int n_err  = 0;
    int ov_cnt = 0;

    uart_rx_os #(
        .clk_freq(1000000), .baud_rate(9600), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a),
        .m_data(m_data_a), .m_frame_err(m_frame_err_a), .m_parity_err(m_parity_err_a),
        .m_valid(m_valid_a), .m_ready(m_ready_a), .overrun(overrun_a), .busy(busy_a)
    );

    uart_rx_os #(
        .clk_freq(1000000), .baud_rate(9600), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b),
        .m_data(m_data_b), .m_frame_err(m_frame_err_b), .m_parity_err(m_parity_err_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .overrun(overrun_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun_a === 1'b1) ov_cnt++;
    end

    typedef struct {
        int         sel;
        logic [7:0] d;
        logic       pe;
        logic       pb;
        logic       sb;
        int         glitch;
        logic [7:0] ed;
        logic       efe;
        logic       epe;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Bit k of a frame starts at clk count round(k * 1e6 / 9600).
    function automatic int bit_edge(input int k);
        return (k * 625 + 3) / 6;
    endfunction

    // {busy, valid, parity_err, frame_err, data}
    function automatic logic [11:0] snap(input int sel);
        if (sel == 0) return {busy_a, m_valid_a, m_parity_err_a, m_frame_err_a, m_data_a};
        return {busy_b, m_valid_b, m_parity_err_b, m_frame_err_b, m_data_b};
    endfunction

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic send_frame(input int sel, input logic [7:0] d, input logic pe,
                              input logic pb, input logic sb, input int glitch);
        logic [10:0] bits;
        int          nb;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        nb = 9;
        if (pe) begin
            bits[9] = pb;
            nb      = 10;
        end
        bits[nb] = sb;
        nb++;
        for (int k = 0; k < nb; k++) begin
            int len;
            len = bit_edge(k + 1) - bit_edge(k);
            set_rx(sel, bits[k]);
            if (k == glitch + 1) begin
                repeat (len / 2) @(negedge clk);
                set_rx(sel, ~bits[k]);
                @(negedge clk);
                set_rx(sel, bits[k]);
                repeat (len - len / 2 - 1) @(negedge clk);
            end else begin
                repeat (len) @(negedge clk);
            end
        end
        set_rx(sel, 1'b1);
    endtask

    task automatic wait_valid(input int sel, input string name);
        logic [11:0] s;
        for (int i = 0; i < 3000; i++) begin
            s = snap(sel);
            if (s[10]) break;
            @(negedge clk);
        end
        s = snap(sel);
        chk({name, "_valid"}, 32'(s[10]), 32'd1);
    endtask

    task automatic chk_head(input int sel, input string name, input logic [7:0] d,
                            input logic fe, input logic pe);
        logic [11:0] s;
        s = snap(sel);
        chk({name, "_data"}, 32'(s[7:0]), 32'(d));
        chk({name, "_ferr"}, 32'(s[8]), 32'(fe));
        chk({name, "_perr"}, 32'(s[9]), 32'(pe));
    endtask

    task automatic pop_head(input int sel);
        if (sel == 0) m_ready_a = 1'b1;
        else          m_ready_b = 1'b1;
        @(negedge clk);
        m_ready_a = 1'b0;
        m_ready_b = 1'b0;
    endtask

    initial begin
        logic [11:0] s;
        logic        seen;
        int          base;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1,  3, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{0, 8'h00, 1'b0, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, -1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, -1, 8'h07, 1'b0, 1'b0};
        vecs[5] = '{1, 8'h07, 1'b1, 1'b0, 1'b1, -1, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{1, 8'h00, 1'b1, 1'b0, 1'b1, -1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{1, 8'hC3, 1'b1, 1'b1, 1'b1, -1, 8'hC3, 1'b0, 1'b1};
        vecs[8] = '{0, 8'h55, 1'b0, 1'b0, 1'b0, -1, 8'h55, 1'b1, 1'b0};
        vecs[9] = '{1, 8'h5A, 1'b1, 1'b0, 1'b0, -1, 8'h5A, 1'b1, 1'b0};

        rst = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        m_ready_a = 1'b0;
        m_ready_b = 1'b0;
        repeat (5) @(negedge clk);
        s = snap(0);
        chk("rst_a_data",  32'(s[7:0]), 32'd0);
        chk("rst_a_ferr",  32'(s[8]), 32'd0);
        chk("rst_a_perr",  32'(s[9]), 32'd0);
        chk("rst_a_valid", 32'(s[10]), 32'd0);
        chk("rst_a_busy",  32'(s[11]), 32'd0);
        chk("rst_a_ovr",   32'(overrun_a), 32'd0);
        s = snap(1);
        chk("rst_b_valid", 32'(s[10]), 32'd0);
        chk("rst_b_busy",  32'(s[11]), 32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);

        // Short low pulse: receiver starts, then rejects it as a false start.
        seen = 1'b0;
        rx_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) rx_a = 1'b1;
            @(negedge clk);
            if (busy_a) seen = 1'b1;
        end
        chk("glitch_busy_rose", 32'(seen), 32'd1);
        repeat (200) @(negedge clk);
        chk("glitch_busy_fell", 32'(busy_a), 32'd0);
        chk("glitch_no_push",   32'(m_valid_a), 32'd0);

        for (int i = 0; i < 10; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            send_frame(vecs[i].sel, vecs[i].d, vecs[i].pe, vecs[i].pb, vecs[i].sb, vecs[i].glitch);
            wait_valid(vecs[i].sel, nm);
            chk_head(vecs[i].sel, nm, vecs[i].ed, vecs[i].efe, vecs[i].epe);
            s = snap(vecs[i].sel);
            chk({nm, "_idle"}, 32'(s[11]), 32'd0);
            pop_head(vecs[i].sel);
            s = snap(vecs[i].sel);
            chk({nm, "_popped"}, 32'(s[10]), 32'd0);
            repeat (50) @(negedge clk);
        end

        // Break: a single 0x00/frame-error entry, then silence until the line rises.
        rx_a = 1'b0;
        repeat (bit_edge(12)) @(negedge clk);
        chk("brk_valid", 32'(m_valid_a), 32'd1);
        chk_head(0, "brk", 8'h00, 1'b1, 1'b0);
        pop_head(0);
        repeat (bit_edge(30) - bit_edge(12)) @(negedge clk);
        chk("brk_no_more", 32'(m_valid_a), 32'd0);
        chk("brk_idle",    32'(busy_a), 32'd0);
        rx_a = 1'b1;
        repeat (bit_edge(2)) @(negedge clk);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        wait_valid(0, "after_brk");
        chk_head(0, "after_brk", 8'h81, 1'b0, 1'b0);
        pop_head(0);
        repeat (50) @(negedge clk);

        // Overrun: five back-to-back frames into a depth-4 FIFO with no consumer.
        base = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_frame(0, 8'(i), 1'b0, 1'b0, 1'b1, -1);
        end
        chk("ovr_none_yet", 32'(ov_cnt - base), 32'd0);
        send_frame(0, 8'h05, 1'b0, 1'b0, 1'b1, -1);
        repeat (50) @(negedge clk);
        chk("ovr_once", 32'(ov_cnt - base), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            string nm;
            nm = $sformatf("drain%0d", i);
            chk({nm, "_valid"}, 32'(m_valid_a), 32'd1);
            chk({nm, "_data"},  32'(m_data_a), 32'(i));
            pop_head(0);
        end
        chk("drain_empty", 32'(m_valid_a), 32'd0);
        repeat (50) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xF0.
        rx_a = 1'b0;
        repeat (bit_edge(5)) @(negedge clk);
        rx_a = 1'b1;
        repeat (52) @(negedge clk);
        chk("mid_busy", 32'(busy_a), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", 32'(busy_a), 32'd0);
        repeat (700) @(negedge clk);
        chk("mid_no_push", 32'(m_valid_a), 32'd0);
        send_frame(0, 8'h0F, 1'b0, 1'b0, 1'b1, -1);
        wait_valid(0, "after_rst");
        chk_head(0, "after_rst", 8'h0F, 1'b0, 1'b0);
        pop_head(0);
        chk("after_rst_popped", 32'(m_valid_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- 16x-oversampled UART receiver for 8-bit frames: optional parity, majority-vote bit sampling, and framing/parity/overrun detection.
- Received bytes go into an internal FIFO and are presented on a valid/ready stream interface.
- Sits at the line-side input of the UART subsystem, beside the existing transmitter and receiver, as the robust receive path for noisy or asynchronous external lines.

Parameters:
- clk_freq, 1000000: system clock frequency in Hz.
- baud_rate, 9600: line bit rate in baud.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity. Ignored when PARITY_EN = 0.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst, input, 1: synchronous, active-low reset.
- rx, input, 1: asynchronous serial line. Idle level is high.
- m_data, output, 8: received byte at the FIFO head.
- m_frame_err, output, 1: stop bit of the head entry sampled low.
- m_parity_err, output, 1: parity mismatch on the head entry.
- m_valid, output, 1: FIFO is not empty.
- m_ready, input, 1: consumer accepts the head entry.
- overrun, output, 1: one-cycle pulse when a completed frame is dropped because the FIFO is full.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst = 0 at a clk edge):
  - State goes to IDLE; FIFO is emptied; tick accumulator is cleared.
  - Both synchroniser flops are set to 1; the line-high arm flag is set.
  - Output reset values: m_valid = 0, m_data = 0, m_frame_err = 0, m_parity_err = 0, overrun = 0, busy = 0.
  - Reset mid-frame discards the partial frame; the partial frame is never pushed.
- Synchroniser: rx passes through 2 flops to give rx_s. All sampling uses rx_s.
- Tick generator:
  - 32-bit accumulator adds baud_rate*16 every clk.
  - When the sum is >= clk_freq, subtract clk_freq and assert os_tick for 1 cycle.
  - Result: exact average rate of 16 ticks per bit.
- State machine: IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE. Every state except IDLE counts os_ticks 0..15.
- Bit value: majority vote of rx_s at ticks 7, 8 and 9.
- IDLE:
  - On an os_tick with rx_s = 0 and the arm flag set, go to START with the tick count at 0.
  - The arm flag clears after a framing error and sets again on any os_tick with rx_s = 1.
- START:
  - At tick 15, a vote of 1 means a false start: return to IDLE with no push and no flag.
  - Otherwise go to DATA with bit index 0.
- DATA:
  - 8 bits, LSB first, 16 ticks each.
  - After bit 7 at tick 15, go to PARITY if PARITY_EN = 1, else to STOP.
- PARITY:
  - Expected bit = XOR of the data bits, inverted when PARITY_ODD = 1.
  - parity_err = voted bit != expected bit.
- STOP:
  - Decide at tick 9, not 15, so the receiver re-arms early for back-to-back frames.
  - frame_err = voted bit == 0.
  - Push {parity_err, frame_err, data} into the FIFO and go to IDLE.
  - If frame_err = 1, clear the arm flag.
- Break condition (line held low): one entry with data 0x00 and frame_err = 1. No further frames until the line returns high.
- FIFO:
  - Push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the frame is dropped and overrun pulses high for that cycle.
  - Pop happens when m_valid && m_ready.
  - m_data, m_frame_err and m_parity_err come from the head entry, held stable while m_valid = 1 and m_ready = 0.
  - Pointers wrap modulo FIFO_DEPTH.
  - Push into an empty FIFO gives m_valid = 1 on the following cycle.
- Latency: m_valid rises about 9.6 bit periods after the start-bit falling edge (10.6 with parity), plus 3 clk.

Decomposition:
- Package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, PARITY, STOP};
  - localparams OS_RATE = 16 and SAMPLE_LO/MID/HI = 7/8/9;
  - function parity_calc(data, odd).
- One sub-module, uart_sync_fifo:
  - parameterised width and depth;
  - ports push/pop/full/empty/count;
  - instantiated with width 10 and depth FIFO_DEPTH.

Test Plan:
- Reset defaults, 8N1: hold rst = 0 for 5 clk with rx = 1 -> all outputs 0, busy = 0. Then drive 0xA5 at 9600 baud (104.17 clk/bit) -> m_valid = 1, m_data = 0xA5, both error flags 0. Pulse m_ready -> m_valid = 0.
- Glitch rejection: a 20-clk low pulse on rx -> busy rises then falls, no push. Next, 0x3C with a single-clk inverted glitch at mid-bit 3 -> m_data = 0x3C.
- Parity: PARITY_EN = 1, PARITY_ODD = 0; send 0x07 with parity bit 1 -> parity_err = 0. Send 0x07 with parity bit 0 -> m_data = 0x07, m_parity_err = 1.
- Framing and break: 0x55 with stop bit 0 -> m_frame_err = 1. Then rx held low for 30 bit times -> exactly one entry {0x00, frame_err = 1} and nothing more until rx rises, after which 0x81 is received cleanly.
- Overrun: m_ready = 0; send 5 back-to-back frames 0x01..0x05 with FIFO_DEPTH = 4 -> overrun pulses once on the 5th frame. Draining yields 0x01..0x04 in order.
- Reset mid-frame: assert rst during DATA bit 4 of 0xF0 -> no push. A following 0x0F is received correctly.
